// File: rtl/line_fill_buffer.sv
// ---------------------------------------------------------------------------
// line_fill_buffer
//
// Purpose:
//   Collects four WORD_SIZE_BIT memory beats into one DATA_BLOCK cache line.
//   The first beat is the critical word. Each beat lands in slot
//   (start + n) mod 4, where start is the requested word offset and n is the
//   beat number. The critical word is also forwarded to the pipeline as a
//   one-cycle pulse. The finished line and its tag are handed to the cache
//   array over a valid/ready handshake.
//
// Configuration:
//   LFB_LOOKUP_EN - when defined, adds a lookup port. A load can then hit a
//                   word of the line while the line is still being filled.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req_valid    miss request present
//   req_ready    buffer can accept a request (IDLE)
//   req_tag      tag of the missing line
//   req_word     word offset of the critical word
//   mem_valid    memory beat present
//   mem_ready    buffer accepts a beat (FILL)
//   mem_data     beat data
//   fill_valid   assembled line ready for the array write (DONE)
//   fill_ready   cache array accepts the line
//   fill_tag     captured tag
//   fill_block   assembled line; word i at [WORD_SIZE_BIT*i +: WORD_SIZE_BIT]
//   crit_valid   one-cycle pulse carrying the critical word
//   crit_data    critical word
//   word_valid   per-slot filled flags
//   busy         buffer is not idle
//   lookup_tag   (LFB_LOOKUP_EN) tag to probe
//   lookup_word  (LFB_LOOKUP_EN) word offset to probe
//   lookup_hit   (LFB_LOOKUP_EN) probed word is present in the buffer
//   lookup_data  (LFB_LOOKUP_EN) probed word
//
// DATA_BLOCK must equal 4*WORD_SIZE_BIT.
// ---------------------------------------------------------------------------
module line_fill_buffer #(
  parameter int WORD_SIZE_BIT = 32,
  parameter int DATA_BLOCK    = 128,
  parameter int TAG           = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TAG-1:0]           req_tag,
  input  logic [1:0]               req_word,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [WORD_SIZE_BIT-1:0] mem_data,
  output logic                     fill_valid,
  input  logic                     fill_ready,
  output logic [TAG-1:0]           fill_tag,
  output logic [DATA_BLOCK-1:0]    fill_block,
  output logic                     crit_valid,
  output logic [WORD_SIZE_BIT-1:0] crit_data,
  output logic [3:0]               word_valid,
  output logic                     busy
`ifdef LFB_LOOKUP_EN
  ,
  input  logic [TAG-1:0]           lookup_tag,
  input  logic [1:0]               lookup_word,
  output logic                     lookup_hit,
  output logic [WORD_SIZE_BIT-1:0] lookup_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] start;
  logic [1:0] cnt;
  logic [1:0] slot;
  logic       beat_accept;

  // Handshake outputs depend only on the state, so no input reaches an
  // output through combinational logic.
  assign req_ready   = (state == IDLE);
  assign mem_ready   = (state == FILL);
  assign fill_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign beat_accept = (state == FILL) && mem_valid;

  // The 2-bit add wraps, which gives the critical-word-first slot order.
  assign slot = start + cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Gaps in mem_valid hold FILL. fill_ready only matters
  // in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = FILL;
      FILL: if (beat_accept && (cnt == 2'd3)) next_state = DONE;
      DONE: if (fill_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line datapath. fill_block is not cleared when a new request starts.
  // word_valid tracks which slots belong to the current line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_tag   <= '0;
      fill_block <= '0;
      word_valid <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      start      <= 2'd0;
      cnt        <= 2'd0;
    end else begin
      crit_valid <= 1'b0;
      if ((state == IDLE) && req_valid) begin
        fill_tag   <= req_tag;
        start      <= req_word;
        cnt        <= 2'd0;
        word_valid <= '0;
      end
      if (beat_accept) begin
        for (int i = 0; i < 4; i++) begin
          if (slot == i[1:0]) begin
            fill_block[i*WORD_SIZE_BIT +: WORD_SIZE_BIT] <= mem_data;
          end
        end
        word_valid[slot] <= 1'b1;
        cnt              <= cnt + 2'd1;
        if (cnt == 2'd0) begin
          crit_data  <= mem_data;
          crit_valid <= 1'b1;
        end
      end
    end
  end

`ifdef LFB_LOOKUP_EN
  // Probe of the line being filled. A slot written on an edge becomes
  // visible through word_valid in the following cycle.
  always_comb begin
    lookup_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (lookup_word == i[1:0]) begin
        lookup_data = fill_block[i*WORD_SIZE_BIT +: WORD_SIZE_BIT];
      end
    end
  end

  assign lookup_hit = busy && (lookup_tag == fill_tag) && word_valid[lookup_word];
`endif

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Refill-side counterpart of the cache's word-select path: collects four WORD_SIZE_BIT beats from memory into one DATA_BLOCK line.
- Words are written into the correct slots in critical-word-first wrap order.
- The assembled line and tag go to the cache array over a valid/ready handshake.
- The first (critical) beat is forwarded to the pipeline immediately.

Parameters:
- WORD_SIZE_BIT, 32, width of one memory beat / CPU word.
- DATA_BLOCK, 128, line width; must equal 4*WORD_SIZE_BIT (4 words per line, 2-bit word offset).
- TAG, 20, tag width carried with the line.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  miss request present.
- req_ready  output  1  buffer can accept a request.
- req_tag  input  TAG  tag of missing line.
- req_word  input  2  offset of the critical word.
- mem_valid  input  1  memory beat present.
- mem_ready  output  1  buffer accepts a beat.
- mem_data  input  WORD_SIZE_BIT  beat data.
- fill_valid  output  1  line assembled, ready for array write.
- fill_ready  input  1  cache array accepts line.
- fill_tag  output  TAG  captured tag.
- fill_block  output  DATA_BLOCK  assembled line; word i occupies bits [WORD_SIZE_BIT*i +: WORD_SIZE_BIT].
- crit_valid  output  1  one-cycle pulse with critical word.
- crit_data  output  WORD_SIZE_BIT  critical word.
- word_valid  output  4  per-slot filled flags.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at posedge, any state): state=IDLE, req_ready=1, mem_ready=0, fill_valid=0, crit_valid=0, word_valid=0, fill_block=0, fill_tag=0, crit_data=0, busy=0, beat counter=0. Reset mid-fill discards the partial line; no fill_valid is produced.
- States: IDLE, FILL, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: capture req_tag and req_word as start offset; clear word_valid and beat counter; go to FILL.
  - Transfer completes on the same edge; fill_block contents are not cleared.
- FILL:
  - req_ready=0, mem_ready=1.
  - Each mem_valid cycle writes mem_data to slot (start+cnt) mod 4 (2-bit wrap), sets word_valid for that slot, and increments cnt.
  - Beat 0 additionally registers crit_data=mem_data and asserts crit_valid for exactly the next cycle.
  - After the 4th beat (cnt==3 accepted): go to DONE.
  - mem_valid gaps stall with no state change.
- DONE:
  - fill_valid=1, mem_ready=0; fill_block and fill_tag held stable.
  - On fill_ready: go to IDLE with fill_valid=0 the next cycle.
  - fill_ready ignored outside DONE.
- Latency:
  - Request accepted at cycle 0.
  - With back-to-back beats, crit_valid is seen in cycle 2 and fill_valid from cycle 5.
  - Minimum occupancy is 6 cycles per line (1 req + 4 beats + 1 handoff).
- No new request is accepted until DONE hands off; req_valid is ignored while busy.
- mem_valid in IDLE or DONE is ignored (mem_ready=0).
- All outputs are registered or derived only from state; no combinational path from inputs to outputs except none.

Optional Feature:
- Macro: LFB_LOOKUP_EN.
- Enabled, adds ports:
  - lookup_tag  input  TAG.
  - lookup_word  input  2.
  - lookup_hit  output  1.
  - lookup_data  output  WORD_SIZE_BIT.
- Enabled, behaviour: combinational lookup_hit = busy & (lookup_tag==fill_tag) & word_valid[lookup_word]. lookup_data = slot lookup_word of fill_block. This lets a load hit a line still being filled.
  - Hit is also valid in DONE.
  - A word written on the current edge becomes visible the cycle after.
- Disabled: the ports are absent and no comparator is built.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles mid-FILL after 2 beats -> word_valid=0, busy=0, fill_valid never asserts, req_ready=1.
- Aligned fill: tag=0x12345, req_word=0, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> crit_data=0xA0 one-cycle pulse; fill_block=0x000000A3_000000A2_000000A1_000000A0; fill_tag=0x12345.
- Wrap fill: req_word=2, beats 0xB0..0xB3 -> slot2=0xB0, slot3=0xB1, slot0=0xB2, slot1=0xB3; crit_data=0xB0.
- Stalls/backpressure: mem_valid toggles 1,0,0,1,1,0,1 and fill_ready held 0 for 5 cycles in DONE -> exactly 4 beats written; fill_block stable; req_valid during DONE not accepted; one fill handoff.
- Lookup (LFB_LOOKUP_EN): req_word=1, after beats 0xC0,0xC1 -> lookup(tag match, word 2) hit=1 data=0xC1; word 0 hit=0; mismatched tag hit=0.
